// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // OPMODE: [1:0] X mux (01 = M), [3:2] Z mux (10 = P); pre-adder, carry-in and subtract all off
  localparam logic [7:0] OPM_MUL_LOAD = 8'h01;
  localparam logic [7:0] OPM_MUL_ACC  = 8'h09;
  localparam logic [7:0] OPM_HOLD     = 8'h08;

  localparam int P_LAT_DEF = 3;
  localparam int P_W       = 48;

  function automatic logic [7:0] tag_opmode(input logic vld, input logic first);
    if (!vld)
      return OPM_HOLD;
    return first ? OPM_MUL_LOAD : OPM_MUL_ACC;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command, operand stream, result and DSP-slice pins of the MAC sequencer.
interface dsp_mac_sequencer_if #(
  parameter int DATA_W = 18,
  parameter int LEN_W  = 10
);
  logic                     cmd_valid;
  logic [LEN_W-1:0]         cmd_len;
  logic                     cmd_ready;
  logic                     abort;
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_a;
  logic signed [DATA_W-1:0] s_b;
  logic                     s_ready;
  logic signed [DATA_W-1:0] dsp_a;
  logic signed [DATA_W-1:0] dsp_b;
  logic [7:0]               dsp_opmode;
  logic                     dsp_ce;
  logic                     dsp_rst;
  logic signed [47:0]       dsp_p;
  logic                     res_valid;
  logic signed [47:0]       res_data;
  logic                     res_ready;

  modport master (
    input  cmd_valid, cmd_len, abort, s_valid, s_a, s_b, dsp_p, res_ready,
    output cmd_ready, s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst,
           res_valid, res_data
  );

  modport slave (
    output cmd_valid, cmd_len, abort, s_valid, s_a, s_b, dsp_p, res_ready,
    input  cmd_ready, s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst,
           res_valid, res_data
  );
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// {vld,first} shift register that delays beat tags to line up with the slice OPMODE register.
module dsp_mac_sequencer_tag_pipe #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_vld,
  input  logic i_first,
  output logic o_vld,
  output logic o_first
);

  // STAGES must be at least 2 for the shift concatenation below
  logic [STAGES-1:0] r_vld_p;
  logic [STAGES-1:0] r_first_p;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p   <= '0;
      r_first_p <= '0;
    end else if (i_flush) begin
      r_vld_p   <= '0;
      r_first_p <= '0;
    end else begin
      r_vld_p   <= {r_vld_p[STAGES-2:0], i_vld};
      r_first_p <= {r_first_p[STAGES-2:0], i_first};
    end
  end

  assign o_vld   = r_vld_p[STAGES-1];
  assign o_first = r_first_p[STAGES-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice through an N-tap signed dot product and holds the P result
// until it is accepted.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int LEN_W  = 10,
  parameter int P_LAT  = P_LAT_DEF
) (
  input logic                 CLK,
  input logic                 RST_N,
  dsp_mac_sequencer_if.master bus
);

  localparam int CNT_W      = $clog2(P_LAT + 1);
  localparam int TAG_STAGES = 2;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [LEN_W-1:0]         r_remaining;
  logic [CNT_W-1:0]         r_drain_cnt;
  logic                     r_first;
  logic                     r_ce;
  logic                     r_dsp_rst;
  logic                     r_res_valid;
  logic signed [P_W-1:0]    r_res_data;
  logic signed [DATA_W-1:0] r_dsp_a;
  logic signed [DATA_W-1:0] r_dsp_b;
  logic                     w_abort;
  logic                     w_beat;
  logic                     w_accept;
  logic                     w_zero_len;
  logic                     w_drain_done;
  logic                     w_tag_vld;
  logic                     w_tag_first;
  logic [7:0]               w_opmode;

  assign w_abort      = bus.abort && (r_state != ST_IDLE);
  assign bus.s_ready  = (r_state == ST_RUN) && (r_remaining != '0) && !bus.abort;
  assign w_beat       = bus.s_valid && bus.s_ready;
  assign w_accept     = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_zero_len   = (bus.cmd_len == '0);
  assign w_drain_done = (r_state == ST_DRAIN) && (r_drain_cnt == CNT_W'(P_LAT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.cmd_ready = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          bus.cmd_ready = 1'b1;
          if (bus.cmd_valid)
            w_state_nxt = w_zero_len ? ST_DONE : ST_RUN;
        end
        ST_RUN:   if (w_beat && r_remaining == LEN_W'(1)) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drain_done) w_state_nxt = ST_DONE;
        ST_DONE:  if (bus.res_ready) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand stage: beat registers the pair onto slice A/B and books one tap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_drain_cnt <= '0;
      r_ce        <= 1'b0;
      r_dsp_rst   <= 1'b1;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
    end else begin
      r_dsp_rst   <= w_abort;
      r_drain_cnt <= ((r_state == ST_DRAIN) && !w_drain_done) ? r_drain_cnt + CNT_W'(1) : '0;
      if (w_beat) begin
        r_dsp_a <= bus.s_a;
        r_dsp_b <= bus.s_b;
      end
      if (w_abort) begin
        r_remaining <= '0;
        r_first     <= 1'b0;
        r_ce        <= 1'b0;
      end else if (w_accept) begin
        r_remaining <= bus.cmd_len;
        r_first     <= 1'b1;
      end else if (w_beat) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_first     <= 1'b0;
        r_ce        <= 1'b1;
      end else if (w_drain_done) begin
        r_ce        <= 1'b0;
      end
    end
  end

  // Result stage: P is sampled once the last product has landed in the P register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (w_abort) begin
      r_res_valid <= 1'b0;
    end else if (w_accept && w_zero_len) begin
      r_res_valid <= 1'b1;
      r_res_data  <= '0;
    end else if (w_drain_done) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.dsp_p;
    end else if (r_state == ST_DONE && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  dsp_mac_sequencer_tag_pipe #(
    .STAGES (TAG_STAGES)
  ) u_tag_pipe (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_flush (w_abort),
    .i_vld   (w_beat),
    .i_first (w_beat && r_first),
    .o_vld   (w_tag_vld),
    .o_first (w_tag_first)
  );

  always_comb begin
    w_opmode = 8'h00;
    if (r_ce)
      w_opmode = tag_opmode(w_tag_vld, w_tag_first);
  end

  assign bus.dsp_a      = r_dsp_a;
  assign bus.dsp_b      = r_dsp_b;
  assign bus.dsp_opmode = w_opmode;
  assign bus.dsp_ce     = r_ce;
  assign bus.dsp_rst    = r_dsp_rst;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice "main" (A1/B1, M, P, OPMODE regs, sync reset).
module tb_dsp_mac_sequencer;

  localparam int DATA_W = 18;
  localparam int LEN_W  = 10;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  dsp_mac_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  dsp_mac_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .P_LAT(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // slice "main": defaults with A1/B1, M, P and OPMODE registers, RSTTYPE = SYNC
  logic signed [17:0] main_a1, main_b1;
  logic signed [47:0] main_m, main_p, main_x, main_z;
  logic [7:0]         main_opm;

  always_comb begin
    main_x = 48'sd0;
    main_z = 48'sd0;
    if (main_opm[1:0] == 2'b01) main_x = main_m;
    if (main_opm[3:2] == 2'b10) main_z = main_p;
  end

  always_ff @(posedge CLK) begin
    if (bus.dsp_rst) begin
      main_a1 <= '0; main_b1 <= '0; main_m <= '0; main_p <= '0; main_opm <= '0;
    end else if (bus.dsp_ce) begin
      main_a1  <= bus.dsp_a;
      main_b1  <= bus.dsp_b;
      main_m   <= $signed({{30{main_a1[17]}}, main_a1}) * $signed({{30{main_b1[17]}}, main_b1});
      main_opm <= bus.dsp_opmode;
      main_p   <= main_opm[7] ? main_z - main_x : main_z + main_x;
    end
  end
  assign bus.dsp_p = main_p;

  int cyc = 0;
  int ce_cnt = 0;
  int rst_cnt = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (bus.dsp_ce === 1'b1)  ce_cnt  <= ce_cnt + 1;
    if (bus.dsp_rst === 1'b1) rst_cnt <= rst_cnt + 1;
  end

  logic signed [DATA_W-1:0] op_a [1024];
  logic signed [DATA_W-1:0] op_b [1024];
  bit          vpat [$];
  logic [47:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [47:0] dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(op_a[i]) * longint'(op_b[i]);
    return acc[47:0];
  endfunction

  function automatic logic [47:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit use_pat, output int beats, output int last_beat);
    int t = 0;
    bit beat;
    beats = 0;
    last_beat = -1;
    while (beats < n && t < 4 * n + 50) begin
      bus.s_valid = use_pat ? ((t < vpat.size()) ? vpat[t] : 1'b1) : 1'b1;
      bus.s_a = op_a[beats];
      bus.s_b = op_b[beats];
      #1;
      beat = bus.s_valid && (bus.s_ready === 1'b1);
      tick();
      if (beat) begin
        beats++;
        last_beat = cyc;
      end
      t++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_result(input int limit, output bit got, output int at);
    got = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        got = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({bus.res_valid, bus.dsp_ce, bus.dsp_rst, bus.cmd_ready, bus.s_ready} !== 5'b00110)
      $display("FAIL reset_ctrl: got %b expected 00110",
               {bus.res_valid, bus.dsp_ce, bus.dsp_rst, bus.cmd_ready, bus.s_ready});
    else n_pass++;
    n_checks++;
    if ({bus.res_data, bus.dsp_a, bus.dsp_b, bus.dsp_opmode} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
               bus.res_data, bus.dsp_a, bus.dsp_b, bus.dsp_opmode);
    else n_pass++;
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (bus.dsp_rst !== 1'b1) $display("FAIL reset_rst_hold: got %b expected 1", bus.dsp_rst);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.dsp_rst !== 1'b0) $display("FAIL reset_rst_release: got %b expected 0", bus.dsp_rst);
    else n_pass++;
  endtask

  task automatic test_basic();
    int beats, last, at;
    bit got;
    logic [47:0] e;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = DATA_W'(i + 1);
      op_b[i] = DATA_W'(i + 5);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL basic_cmd_ready: got %b expected 1", bus.cmd_ready);
    else n_pass++;
    exp_q.push_back(dot(4));
    send_cmd(4);
    feed(4, 1'b0, beats, last);
    n_checks++;
    if (beats != 4 || bus.dsp_ce !== 1'b1)
      $display("FAIL basic_run: got beats=%0d ce=%b expected 4 and 1", beats, bus.dsp_ce);
    else n_pass++;
    wait_result(20, got, at);
    n_checks++;
    if (!got || at - last != 4) $display("FAIL basic_latency: got %0d cycles expected 4", at - last);
    else n_pass++;
    e = pop_exp();
    n_checks++;
    if (bus.res_data !== e) $display("FAIL basic_data: got %h expected %h", bus.res_data, e);
    else n_pass++;
    accept_result();
    n_checks++;
    if ({bus.res_valid, bus.cmd_ready, bus.dsp_ce} !== 3'b010)
      $display("FAIL basic_release: got %b expected 010", {bus.res_valid, bus.cmd_ready, bus.dsp_ce});
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int beats, last, at;
    bit got;
    logic [47:0] e, r_bub;
    op_a[0] = -18'sd3;    op_b[0] = 18'sd7;
    op_a[1] = 18'sd100;   op_b[1] = -18'sd2;
    op_a[2] = 18'sh20000; op_b[2] = 18'sd131071;
    vpat.delete();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.push_back(dot(3));
    send_cmd(3);
    feed(3, 1'b1, beats, last);
    wait_result(20, got, at);
    n_checks++;
    if (!got || beats != 3 || at - last != 4)
      $display("FAIL bubble_latency: got beats=%0d lat=%0d expected 3 and 4", beats, at - last);
    else n_pass++;
    e = pop_exp();
    r_bub = bus.res_data;
    n_checks++;
    if (bus.res_data !== e) $display("FAIL bubble_data: got %h expected %h", bus.res_data, e);
    else n_pass++;
    accept_result();
    exp_q.push_back(dot(3));
    send_cmd(3);
    feed(3, 1'b0, beats, last);
    wait_result(20, got, at);
    e = pop_exp();
    n_checks++;
    if (!got || bus.res_data !== e || bus.res_data !== r_bub)
      $display("FAIL bubble_free_data: got %h expected %h", bus.res_data, e);
    else n_pass++;
    accept_result();
  endtask

  task automatic test_zero_len();
    int c0;
    bit got = 1'b0;
    logic [47:0] e;
    c0 = ce_cnt;
    exp_q.push_back(dot(0));
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = '0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      bus.cmd_valid = 1'b0;
      if (bus.res_valid === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL zero_valid: got %b expected 1 within 2 cycles", bus.res_valid);
    else n_pass++;
    e = pop_exp();
    n_checks++;
    if (bus.res_data !== e) $display("FAIL zero_data: got %h expected %h", bus.res_data, e);
    else n_pass++;
    accept_result();
    tick();
    n_checks++;
    if (ce_cnt != c0) $display("FAIL zero_ce: got %0d ce cycles expected 0", ce_cnt - c0);
    else n_pass++;
  endtask

  task automatic test_max_len();
    int beats, last, at;
    bit got;
    logic [47:0] e;
    for (int i = 0; i < 1023; i++) begin
      op_a[i] = 18'sh20000;
      op_b[i] = 18'sh20000;
    end
    exp_q.push_back(dot(1023));
    send_cmd(1023);
    feed(1023, 1'b0, beats, last);
    wait_result(20, got, at);
    e = pop_exp();
    n_checks++;
    if (!got || beats != 1023 || bus.res_data !== e)
      $display("FAIL max_len_data: got %h expected %h (beats %0d)", bus.res_data, e, beats);
    else n_pass++;
    accept_result();
  endtask

  task automatic test_abort();
    int r0, beats, last, at, stray;
    bit got;
    logic [47:0] e;
    for (int i = 0; i < 5; i++) begin
      op_a[i] = DATA_W'(11 * (i + 1));
      op_b[i] = DATA_W'(-7 * (i + 2));
    end
    r0 = rst_cnt;
    send_cmd(5);
    bus.s_valid = 1'b1; bus.s_a = op_a[0]; bus.s_b = op_b[0];
    tick();
    bus.s_a = op_a[1]; bus.s_b = op_b[1];
    bus.abort = 1'b1;
    #1;
    n_checks++;
    if (bus.s_ready !== 1'b0) $display("FAIL abort_s_ready: got %b expected 0", bus.s_ready);
    else n_pass++;
    tick();
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    n_checks++;
    if ({bus.dsp_rst, bus.cmd_ready, bus.res_valid, bus.dsp_ce} !== 4'b1100)
      $display("FAIL abort_state: got %b expected 1100",
               {bus.dsp_rst, bus.cmd_ready, bus.res_valid, bus.dsp_ce});
    else n_pass++;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.res_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0 || rst_cnt - r0 != 1)
      $display("FAIL abort_pulse: got res_valid=%0d rst_pulses=%0d expected 0 and 1", stray, rst_cnt - r0);
    else n_pass++;
    op_a[0] = 18'sd2;
    op_b[0] = 18'sd3;
    exp_q.push_back(dot(1));
    send_cmd(1);
    feed(1, 1'b0, beats, last);
    wait_result(20, got, at);
    e = pop_exp();
    n_checks++;
    if (!got || bus.res_data !== e) $display("FAIL abort_next_data: got %h expected %h", bus.res_data, e);
    else n_pass++;
    accept_result();
  endtask

  task automatic test_hold_and_reset();
    int beats, last, at, bad;
    bit got;
    logic [47:0] e;
    logic [47:0] held;
    op_a[0] = -18'sd1234; op_b[0] = 18'sd4321;
    op_a[1] = 18'sd999;   op_b[1] = -18'sd77;
    exp_q.push_back(dot(2));
    send_cmd(2);
    feed(2, 1'b0, beats, last);
    wait_result(20, got, at);
    held = bus.res_data;
    e = pop_exp();
    n_checks++;
    if (!got || held !== e) $display("FAIL hold_data: got %h expected %h", held, e);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.cmd_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    else n_pass++;
    accept_result();
    send_cmd(4);
    bus.s_valid = 1'b1;
    bus.s_a = 18'sd5; bus.s_b = 18'sd6;
    tick();
    tick();
    RST_N = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.res_valid, bus.dsp_ce, bus.dsp_rst, bus.cmd_ready, bus.s_ready} !== 5'b00110)
      $display("FAIL midrun_reset_ctrl: got %b expected 00110",
               {bus.res_valid, bus.dsp_ce, bus.dsp_rst, bus.cmd_ready, bus.s_ready});
    else n_pass++;
    n_checks++;
    if ({bus.res_data, bus.dsp_a, bus.dsp_b, bus.dsp_opmode} !== '0)
      $display("FAIL midrun_reset_data: got %h/%h/%h/%h expected all 0",
               bus.res_data, bus.dsp_a, bus.dsp_b, bus.dsp_opmode);
    else n_pass++;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    n_checks++;
    if ({bus.dsp_rst, bus.cmd_ready} !== 2'b01)
      $display("FAIL midrun_release: got %b expected 01", {bus.dsp_rst, bus.cmd_ready});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int beats, last, at;
    bit got;
    logic [47:0] e;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        op_a[i] = DATA_W'($urandom);
        op_b[i] = DATA_W'($urandom);
      end
      vpat.delete();
      for (int j = 0; j < 20; j++) vpat.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(dot(6));
      send_cmd(6);
      feed(6, 1'b1, beats, last);
      wait_result(20, got, at);
      e = pop_exp();
      n_checks++;
      if (!got || beats != 6 || at - last != 4 || bus.res_data !== e)
        $display("FAIL b2b_%0d: got %h lat=%0d expected %h lat=4", k, bus.res_data, at - last, e);
      else n_pass++;
      accept_result();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_a       = '0;
    bus.s_b       = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_max_len();
    test_abort();
    test_back_to_back();
    test_hold_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
